// File: rtl/inst_loader.sv
// inst_loader: framed-stream program loader; define INST_LOADER_FILL_EN to zero-fill memory above the program.
module inst_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len
);
  typedef enum logic [2:0] {
    IDLE, LEN, DATA, CHECK, DONE, ERROR
`ifdef INST_LOADER_FILL_EN
    , FILL
`endif
  } state_t;
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);
`ifdef INST_LOADER_FILL_EN
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
`endif
  state_t state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, idx_q, idx_d, len_q, len_d;
  logic [7:0]        sum_q, sum_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              xfer, len_ok, sum_ok;
  logic [7:0]        sum_nx;
  logic [ADDR_W:0]   idx_inc;
  assign xfer    = in_valid && in_ready;
  assign len_ok  = (in_data != 8'h00) && ({1'b0, in_data} <= DEPTH9);
  assign sum_nx  = sum_q + in_data;
  assign sum_ok  = sum_nx == 8'h00;
  assign idx_inc = idx_q + 1'b1;
  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Next-state logic: frame sequencing and restart on start from idle states
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: state_d = start ? LEN : state_q;
      LEN:   state_d = xfer ? (len_ok ? DATA : ERROR) : state_q;
      DATA:  state_d = (xfer && idx_inc == cnt_q) ? CHECK : state_q;
`ifdef INST_LOADER_FILL_EN
      CHECK: state_d = xfer ? (sum_ok ? (cnt_q == DEPTH_W ? DONE : FILL) : ERROR) : state_q;
      FILL:  state_d = (idx_q == LAST) ? DONE : state_q;
`else
      CHECK: state_d = xfer ? (sum_ok ? DONE : ERROR) : state_q;
`endif
      default: state_d = IDLE;
    endcase
  end
  // Status outputs decoded from the current state
  always_comb begin
    in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);
    cpu_run  = state_q == DONE;
    load_err = state_q == ERROR;
  end
  // Datapath next values: count/index, running checksum and the registered write port
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERROR: sum_d = start ? 8'h00 : sum_q;
      LEN: if (xfer && len_ok) begin
        cnt_d = in_data[ADDR_W:0];
        idx_d = '0;
        sum_d = in_data;
      end
      DATA: if (xfer) begin
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = in_data;
        sum_d   = sum_nx;
        idx_d   = idx_inc;
      end
      CHECK: len_d = (xfer && sum_ok) ? cnt_q : len_q;
`ifdef INST_LOADER_FILL_EN
      FILL: begin
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = 8'h00;
        idx_d   = idx_inc;
      end
`endif
      default: ;
    endcase
  end
  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign prog_len  = len_q;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized frames checked against a frame-level model of loader behaviour.
module tb_inst_loader;
`ifdef INST_LOADER_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  logic       clk = 0, reset = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, mem_we, cpu_run, load_err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [4:0] prog_len;
  int n = 0, errs = 0, cyc = 0, prev_len = 0;
  logic [7:0]  frame[$];
  int          xcyc[$];
  logic [31:0] got[$];

  inst_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .load_err(load_err), .prog_len(prog_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_we) got.push_back({cyc[15:0], 4'h0, mem_addr, mem_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    check("start_run", cpu_run, 0);
    check("start_err", load_err, 0);
    check("start_rdy", in_ready, 1);
  endtask

  task automatic send(input int gap, input bit stray);
    int i = 0, t = 0;
    while (i < frame.size() && t < 400) begin
      @(negedge clk);
      start = 0;
      t++;
      if ($urandom_range(99) < gap) begin
        in_valid = 0;
        in_data = 8'($urandom);
      end else begin
        in_valid = 1;
        in_data = frame[i];
        if (in_ready) begin
          xcyc.push_back(cyc);
          i++;
        end
      end
      if (stray && in_ready && $urandom_range(3) == 0) start = 1;
    end
    if (i < frame.size()) check("send_timeout", i, frame.size());
    @(negedge clk);
    in_valid = 0;
    start = 0;
  endtask

  task automatic rand_frame(input int len, input bit bad);
    logic [7:0] s, b;
    frame.delete();
    frame.push_back(8'(len));
    s = 8'(len);
    if (len >= 1 && len <= 16) begin
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        frame.push_back(b);
        s += b;
      end
      b = 8'h00 - s;
      if (bad) b ^= 8'(1 << $urandom_range(7));
      frame.push_back(b);
    end
  endtask

  task automatic do_load(input int gap, input bit stray);
    int len, c, dn, w;
    logic [7:0] s;
    bit legal, good;
    logic [31:0] exp[$];
    pulse_start();
    got.delete();
    xcyc.delete();
    send(gap, stray);
    if (xcyc.size() != frame.size()) return;
    len = int'(frame[0]);
    legal = len >= 1 && len <= 16;
    s = 0;
    foreach (frame[k]) s += frame[k];
    good = legal && s == 8'h00;
    c = xcyc[xcyc.size()-1];
    check("rdy_after", in_ready, 0);
    if (legal)
      for (int k = 0; k < len; k++) exp.push_back({16'(xcyc[k+1] + 1), 4'h0, 4'(k), frame[k+1]});
    if (FILL && good)
      for (int a = len; a < 16; a++) exp.push_back({16'(c + 2 + a - len), 4'h0, 4'(a), 8'h00});
    dn = c + 1 + ((FILL && good) ? 16 - len : 0);
    w = 0;
    while (!(cpu_run || load_err) && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("end_cyc", cyc, dn);
    check("cpu_run", cpu_run, good);
    check("load_err", load_err, !good);
    if (good) prev_len = len;
    check("prog_len", prog_len, prev_len);
    repeat (2) @(negedge clk);
    check("n_writes", got.size(), exp.size());
    foreach (exp[k]) if (k < got.size()) check("write", got[k], exp[k]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdy", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_run", cpu_run, 0);
    check("rst_err", load_err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_len", prog_len, 0);
    reset = 0;
    frame = '{8'h03, 8'h1B, 8'h62, 8'hA4, 8'hDC};
    do_load(0, 0);
    frame = '{8'h03, 8'h1B, 8'h62, 8'hA4, 8'hDD};
    do_load(0, 0);
    frame = '{8'h00};
    do_load(0, 0);
    frame = '{8'h11};
    do_load(0, 0);
    frame = '{8'h03, 8'h1B, 8'h62, 8'hA4, 8'hDC};
    do_load(30, 1);
    rand_frame(16, 0);
    do_load(40, 0);
    pulse_start();
    got.delete();
    xcyc.delete();
    frame = '{8'h03, 8'h1B, 8'h62};
    send(20, 1);
    reset = 1;
    in_valid = 1;
    in_data = 8'hA4;
    @(negedge clk);
    reset = 0;
    check("mid_rdy", in_ready, 0);
    check("mid_we", mem_we, 0);
    check("mid_run", cpu_run, 0);
    check("mid_err", load_err, 0);
    check("mid_addr", mem_addr, 0);
    check("mid_len", prog_len, 0);
    prev_len = 0;
    repeat (5) @(negedge clk);
    in_valid = 0;
    check("mid_writes", got.size(), 2);
    check("mid_w0", got[0][15:0], 16'h001B);
    check("mid_w1", got[1][15:0], 16'h0162);
    for (int r = 0; r < 30; r++) begin
      int len;
      len = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 0 : $urandom_range(17, 255))
                                     : $urandom_range(1, 16);
      rand_frame(len, $urandom_range(3) == 0);
      do_load($urandom_range(60), 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
